inst_buffer: RTL and testbench

- Instruction FIFO between the fetch stage and the decoders (id_* modules).
- Accepts up to two fetched instructions per cycle, each with pc, inst and fetch-side exception information.
- Presents the two oldest entries, in program order, to decoder slots 0/1.
- Decouples fetch stalls from decode/dispatch stalls and discards all contents on a pipeline flush.

---
 rtl/inst_buffer.sv | 122 ++++++++++++
 tb/tb_inst_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Instruction FIFO between fetch and the decoders: up to two entries in and two out per cycle.
// Latency: an entry pushed in cycle N is visible on dec slot 0 in cycle N+1 at the earliest.
// Backpressure: buffer_stall is raised when fewer than 2 entries are free; a push that does not fit is dropped whole.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        fetch_valid,
  input  logic [31:0]       fetch_pc0,
  input  logic [31:0]       fetch_pc1,
  input  logic [31:0]       fetch_inst0,
  input  logic [31:0]       fetch_inst1,
  input  logic [1:0]        fetch_exc,
  input  logic [6:0]        fetch_exc_cause0,
  input  logic [6:0]        fetch_exc_cause1,
  output logic              buffer_stall,
  input  logic              dec_ready,
  output logic [1:0]        dec_valid,
  output logic [31:0]       dec_pc0,
  output logic [31:0]       dec_pc1,
  output logic [31:0]       dec_inst0,
  output logic [31:0]       dec_inst1,
  output logic [1:0]        dec_exc,
  output logic [6:0]        dec_exc_cause0,
  output logic [6:0]        dec_exc_cause1,
  output logic [PTR_W:0]    entry_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [6:0]  cause;
  } entry_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [1:0]       enq_n;
  logic [1:0]       enq_acc;
  logic [1:0]       deq_n;
  logic             push_ok;
  entry_t           ent0, ent1;
  entry_t           slot0, slot1;

  assign ent0 = '{pc: fetch_pc0, inst: fetch_inst0, exc: fetch_exc[0], cause: fetch_exc_cause0};
  assign ent1 = '{pc: fetch_pc1, inst: fetch_inst1, exc: fetch_exc[1], cause: fetch_exc_cause1};

  // Push/pop sizing; room is judged on the occupancy before this cycle's pop.
  always_comb begin
    enq_n   = 2'(fetch_valid[0]) + 2'(fetch_valid[1]);
    deq_n   = dec_ready ? (2'(dec_valid[0]) + 2'(dec_valid[1])) : 2'd0;
    push_ok = !flush && ((DEPTH_C - count_q) >= (PTR_W+1)'(enq_n));
    enq_acc = push_ok ? enq_n : 2'd0;
  end

  // Next pointer/occupancy state; flush wins over any push or pop.
  always_comb begin
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_acc);
    count_d = count_q + (PTR_W+1)'(enq_acc) - (PTR_W+1)'(deq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; a lone slot-1 instruction lands at tail just like a lone slot-0 one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      if (fetch_valid == 2'b11) begin
        mem_q[tail_q]             <= ent0;
        mem_q[tail_q + PTR_W'(1)] <= ent1;
      end else if (fetch_valid[0]) begin
        mem_q[tail_q] <= ent0;
      end else if (fetch_valid[1]) begin
        mem_q[tail_q] <= ent1;
      end
    end
  end

  // Output slots read the two oldest entries straight from storage (no bypass).
  always_comb begin
    slot0 = mem_q[head_q];
    slot1 = mem_q[head_q + PTR_W'(1)];
  end

  assign dec_valid      = {count_q >= (PTR_W+1)'(2), count_q != '0};
  assign dec_pc0        = slot0.pc;
  assign dec_pc1        = slot1.pc;
  assign dec_inst0      = slot0.inst;
  assign dec_inst1      = slot1.inst;
  assign dec_exc        = {slot1.exc, slot0.exc};
  assign dec_exc_cause0 = slot0.cause;
  assign dec_exc_cause1 = slot1.cause;
  assign buffer_stall   = (DEPTH_C - count_q) < (PTR_W+1)'(2);
  assign entry_count    = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_inst_buffer;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic [1:0] fetch_valid = 0;
  logic [31:0] fetch_pc0 = 0, fetch_pc1 = 0, fetch_inst0 = 0, fetch_inst1 = 0;
  logic [1:0] fetch_exc = 0;
  logic [6:0] fetch_exc_cause0 = 0, fetch_exc_cause1 = 0;
  logic dec_ready = 0;
  logic buffer_stall;
  logic [1:0] dec_valid, dec_exc;
  logic [31:0] dec_pc0, dec_pc1, dec_inst0, dec_inst1;
  logic [6:0] dec_exc_cause0, dec_exc_cause1;
  logic [PTR_W:0] entry_count;

  inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1), .fetch_exc(fetch_exc),
    .fetch_exc_cause0(fetch_exc_cause0), .fetch_exc_cause1(fetch_exc_cause1),
    .buffer_stall(buffer_stall), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_pc0(dec_pc0), .dec_pc1(dec_pc1), .dec_inst0(dec_inst0), .dec_inst1(dec_inst1),
    .dec_exc(dec_exc), .dec_exc_cause0(dec_exc_cause0), .dec_exc_cause1(dec_exc_cause1),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [6:0]  cause;
  } ent_t;

  ent_t mq[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DEPTH-visible output against the model; data only for valid slots.
  task automatic check_outputs();
    int sz = mq.size();
    check("entry_count", 64'(entry_count), 64'(sz));
    check("dec_valid", 64'(dec_valid), 64'({sz >= 2, sz >= 1}));
    check("buffer_stall", 64'(buffer_stall), 64'((DEPTH - sz) < 2));
    if (sz >= 1) begin
      check("pc0", 64'(dec_pc0), 64'(mq[0].pc));
      check("inst0", 64'(dec_inst0), 64'(mq[0].inst));
      check("exc0", 64'(dec_exc[0]), 64'(mq[0].exc));
      check("cause0", 64'(dec_exc_cause0), 64'(mq[0].cause));
    end
    if (sz >= 2) begin
      check("pc1", 64'(dec_pc1), 64'(mq[1].pc));
      check("inst1", 64'(dec_inst1), 64'(mq[1].inst));
      check("exc1", 64'(dec_exc[1]), 64'(mq[1].exc));
      check("cause1", 64'(dec_exc_cause1), 64'(mq[1].cause));
    end
  endtask

  // One cycle: check current outputs, drive new inputs, advance the model.
  task automatic step(input logic [1:0] v, input logic rdy, input logic fl,
                      input logic [1:0] exc, input logic [6:0] c0, input logic [6:0] c1);
    ent_t e0, e1;
    int enq, deq;
    @(negedge clk);
    check_outputs();
    fetch_valid = v; dec_ready = rdy; flush = fl; fetch_exc = exc;
    fetch_pc0 = pc_ctr; fetch_pc1 = pc_ctr + 4; pc_ctr += 8;
    fetch_inst0 = $urandom; fetch_inst1 = $urandom;
    fetch_exc_cause0 = c0; fetch_exc_cause1 = c1;
    e0 = '{fetch_pc0, fetch_inst0, exc[0], c0};
    e1 = '{fetch_pc1, fetch_inst1, exc[1], c1};
    if (fl) begin
      mq.delete();
    end else begin
      enq = int'(v[0]) + int'(v[1]);
      deq = rdy ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
      if ((DEPTH - mq.size()) >= enq) begin
        repeat (deq) void'(mq.pop_front());
        if (v[0]) mq.push_back(e0);
        if (v[1]) mq.push_back(e1);
      end else begin
        repeat (deq) void'(mq.pop_front());
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, rdy, 1'b0, 2'b00, 7'd0, 7'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; flush = 0; fetch_valid = 0; dec_ready = 0; fetch_exc = 0;
    mq.delete();
    @(negedge clk);
    check("rst_valid", 64'(dec_valid), 64'd0);
    check("rst_count", 64'(entry_count), 64'd0);
    check("rst_stall", 64'(buffer_stall), 64'd0);
    check("rst_pc0", 64'(dec_pc0), 64'd0);
    check("rst_pc1", 64'(dec_pc1), 64'd0);
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // 1: two-wide push into empty buffer appears next cycle
    pc_ctr = 32'h1c00_0000;
    @(negedge clk);
    fetch_valid = 2'b11; dec_ready = 0;
    fetch_pc0 = 32'h1c00_0000; fetch_pc1 = 32'h1c00_0004;
    fetch_inst0 = 32'h0648_3800; fetch_inst1 = 32'h0000_6000;
    fetch_exc = 0; fetch_exc_cause0 = 0; fetch_exc_cause1 = 0;
    mq.push_back('{32'h1c00_0000, 32'h0648_3800, 1'b0, 7'd0});
    mq.push_back('{32'h1c00_0004, 32'h0000_6000, 1'b0, 7'd0});
    pc_ctr = 32'h1c00_0008;
    @(negedge clk);
    fetch_valid = 0;
    check("t1_valid", 64'(dec_valid), 64'd3);
    check("t1_pc0", 64'(dec_pc0), 64'h1c00_0000);
    check("t1_pc1", 64'(dec_pc1), 64'h1c00_0004);
    check("t1_inst0", 64'(dec_inst0), 64'h0648_3800);
    check("t1_count", 64'(entry_count), 64'd2);

    // 2: steady state with 3 entries, push 2 / pop 2
    step(2'b01, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 1'b0, 2'b00, 7'd0, 7'd0);
    step(2'b00, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    check("t2_count", 64'(entry_count), 64'd3);

    // 3: fill to 15, then overflow behaviour
    do_reset();
    for (int i = 0; i < 7; i++) step(2'b11, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    step(2'b01, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t3_stall15", 64'(buffer_stall), 64'd1);
    check("t3_count15", 64'(entry_count), 64'd15);
    step(2'b11, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t3_drop2", 64'(entry_count), 64'd15);
    step(2'b10, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t3_full", 64'(entry_count), 64'd16);
    step(2'b01, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t3_drop1", 64'(entry_count), 64'd16);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // 4: walk head to 15 with two entries, then pop across the wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(2'b01, 1'b1, 1'b0, 2'b00, 7'd0, 7'd0);
    step(2'b10, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t4_count", 64'(entry_count), 64'd2);
    check("t4_wrap_pc1", 64'(dec_pc1), 64'(pc_ctr - 32'd12));
    idle(1'b1);
    step(2'b01, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t4_after", 64'(dec_valid), 64'd1);

    // 5: fetch exception carried on slot 0 only
    do_reset();
    step(2'b11, 1'b0, 1'b0, 2'b01, 7'h08, 7'h00);
    idle(1'b0);
    check("t5_exc", 64'(dec_exc), 64'd1);
    check("t5_cause0", 64'(dec_exc_cause0), 64'h08);

    // 6: flush beats push and pop; then asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t6_six", 64'(entry_count), 64'd6);
    step(2'b11, 1'b1, 1'b1, 2'b00, 7'd0, 7'd0);
    idle(1'b0);
    check("t6_valid", 64'(dec_valid), 64'd0);
    check("t6_count", 64'(entry_count), 64'd0);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_arst_valid", 64'(dec_valid), 64'd0);
    check("t6_arst_count", 64'(entry_count), 64'd0);
    check("t6_arst_pc0", 64'(dec_pc0), 64'd0);
    fetch_valid = 0; flush = 0; dec_ready = 0;
    mq.delete();
    @(negedge clk);
    rst_n = 1;

    // Random traffic; fetch sometimes ignores stall so drops occur.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] v;
      logic rdy, fl;
      v = 2'($urandom);
      if (buffer_stall && ($urandom_range(0, 3) != 0)) v = 2'b00;
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 60 : 25));
      fl = ($urandom_range(0, 99) < 3);
      step(v, rdy, fl, 2'($urandom), 7'($urandom), 7'($urandom));
    end
    @(negedge clk);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
